data_bus_arb: RTL
=================

DATA_BUS_ARB -- requirements
Module: data_bus_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, RAM word-address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, data bus width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum wait cycles for a response (1..255).
REQ-004 SHALL have port clk_i  input  1  the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports m0_req_i, m1_req_i  input  1  request from m0 (UART loader) and m1 (CPU data port).
REQ-007 SHALL have ports m0_we_i, m1_we_i  input  1  write enable, 1 = write.
REQ-008 SHALL have ports m0_addr_i, m1_addr_i  input  ADDR_W  request address.
REQ-009 SHALL have ports m0_be_i, m1_be_i  input  DATA_W/8  byte enables.
REQ-010 SHALL have ports m0_wdata_i, m1_wdata_i  input  DATA_W  write data.
REQ-011 SHALL have ports m0_gnt_o, m1_gnt_o  output  1  request accepted this cycle.
REQ-012 SHALL have ports m0_rvalid_o, m1_rvalid_o  output  1  response valid.
REQ-013 SHALL have ports m0_rdata_o, m1_rdata_o  output  DATA_W  read data; 0 when the matching rvalid is 0.
REQ-014 SHALL have ports m0_err_o, m1_err_o  output  1  one-cycle response-timeout pulse.
REQ-015 SHALL have ports s_req_o, s_we_o  output  1, and s_addr_o  output  ADDR_W, s_be_o  output  DATA_W/8, s_wdata_o  output  DATA_W: request to the single RAM port.
REQ-016 SHALL have ports s_gnt_i, s_rvalid_i  input  1, and s_rdata_i  input  DATA_W: RAM grant, response valid and read data.

Function
REQ-017 SHALL implement states IDLE and WAIT; at most one transaction SHALL be outstanding at any time.
REQ-018 SHALL be able to accept a new request in IDLE, and in WAIT during the cycle in which s_rvalid_i=1 (back-to-back issue).
REQ-019 SHALL, when able to accept, select one requesting master and drive s_req_o and all s_* request fields combinationally from that master; s_req_o SHALL be 0 otherwise.
REQ-020 SHALL assert the selected master's gnt_o combinationally equal to s_gnt_i; the other master's gnt_o SHALL be 0.
REQ-021 SHALL, on a granted cycle (s_req_o & s_gnt_i), register owner := selected master, enter WAIT and clear the wait counter.
REQ-022 SHALL, in WAIT with s_rvalid_i=1, pulse owner's rvalid_o and pass s_rdata_i to owner's rdata_o in the same cycle (zero added latency), then go to IDLE unless a new grant occurs in that cycle.
REQ-023 SHALL treat write responses identically to read responses: every granted transaction receives exactly one rvalid.
REQ-024 SHALL ignore s_rvalid_i in IDLE: no rvalid_o is raised.
REQ-025 SHALL increment the wait counter each WAIT cycle without s_rvalid_i; when it reaches TIMEOUT it SHALL pulse owner's err_o for one cycle, return to IDLE and grant nothing in that cycle.
REQ-026 SHALL keep a held request unchanged while not granted; the block does not latch request fields.
REQ-027 SHALL give m0 fixed priority over m1 when both request (unless REQ-033 applies).

Reset
REQ-028 SHALL, while rst_i=1, force state IDLE, owner=m0, wait counter=0, last-winner=m1.
REQ-029 SHALL, during reset, hold every output at 0.
REQ-030 SHALL drop an outstanding transaction on reset mid-operation: no rvalid_o or err_o for it after reset deasserts.
REQ-031 SHALL make the first arbitration after reset pick m0 under either configuration.

Configuration
REQ-032 SHALL recognise the macro DATA_BUS_ARB_RR_EN.
REQ-033 SHALL, with DATA_BUS_ARB_RR_EN defined, give the conflicting master that was not the last winner priority, updating last-winner only on a granted cycle.
REQ-034 SHALL, without DATA_BUS_ARB_RR_EN, use fixed m0 priority and include no last-winner register.

Verification
REQ-035 SHALL cover a single m1 read: addr 0x010, s_gnt_i=1, RAM returns 0xDEADBEEF next cycle -> m1_rvalid_o=1 with m1_rdata_o=0xDEADBEEF, m0_rvalid_o=0.
REQ-036 SHALL cover simultaneous requests (m0 write 0x004, m1 read 0x008) for four transactions: without the macro -> m0, m0, m0, m0; with the macro -> m0, m1, m0, m1.
REQ-037 SHALL cover a back-to-back case: m1 holds req, RAM asserts rvalid every cycle -> m1_gnt_o=1 every cycle after the first and one rvalid per grant.
REQ-038 SHALL cover a timeout: grant m0, s_rvalid_i held 0 -> m0_err_o pulses exactly TIMEOUT=15 cycles after the grant, then m1 is grantable the following cycle.
REQ-039 SHALL cover reset in WAIT: rst_i pulsed during WAIT, late s_rvalid_i=1 after reset -> no rvalid_o, all outputs 0 during reset.

Source files
------------

// File: rtl/data_bus_arb.sv
// Two-master to single-RAM-port arbiter with at most one outstanding transaction and a response timeout.
// Define DATA_BUS_ARB_RR_EN to alternate priority on conflicts; otherwise m0 always wins.
module data_bus_arb #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    output logic                m0_err_o,

    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                m1_err_o,

    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W/8-1:0] s_be_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic                s_gnt_i,
    input  logic                s_rvalid_i,
    input  logic [DATA_W-1:0]   s_rdata_i
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;   // 0 = m0, 1 = m1
    logic [7:0] cnt_q, cnt_d;
    logic       sel;                // selected master, 0 = m0, 1 = m1
    logic       can_accept;
    logic       granted;
    logic       resp;
    logic       tmo;

`ifdef DATA_BUS_ARB_RR_EN
    logic last_q;                   // 1 = m1 won the last granted cycle

    // On conflict the master that did not win last time goes first.
    assign sel = m1_req_i & (~m0_req_i | ~last_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        last_q <= 1'b1;
        else if (granted) last_q <= sel;
    end
`else
    assign sel = m1_req_i & ~m0_req_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        s_req_o     = 1'b0;
        s_we_o      = 1'b0;
        s_addr_o    = '0;
        s_be_o      = '0;
        s_wdata_o   = '0;
        m0_gnt_o    = 1'b0;
        m1_gnt_o    = 1'b0;
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m0_rdata_o  = '0;
        m1_rdata_o  = '0;
        m0_err_o    = 1'b0;
        m1_err_o    = 1'b0;

        // A response frees the port in the same cycle, allowing back-to-back issue.
        can_accept = ~rst_i & ((state_q == IDLE) | s_rvalid_i);
        resp       = ~rst_i & (state_q == WAIT) & s_rvalid_i;
        tmo        = ~rst_i & (state_q == WAIT) & ~s_rvalid_i & (cnt_q == CNT_LAST);

        if (can_accept & (m0_req_i | m1_req_i)) begin
            s_req_o   = 1'b1;
            s_we_o    = sel ? m1_we_i    : m0_we_i;
            s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
            s_be_o    = sel ? m1_be_i    : m0_be_i;
            s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
        end
        granted  = s_req_o & s_gnt_i;
        m0_gnt_o = granted & ~sel;
        m1_gnt_o = granted & sel;

        if (resp) begin
            m0_rvalid_o = ~owner_q;
            m1_rvalid_o = owner_q;
            m0_rdata_o  = owner_q ? '0 : s_rdata_i;
            m1_rdata_o  = owner_q ? s_rdata_i : '0;
        end
        m0_err_o = tmo & ~owner_q;
        m1_err_o = tmo & owner_q;

        if (granted) begin
            state_d = WAIT;
            owner_d = sel;
            cnt_d   = 8'd0;
        end else if (resp | tmo) begin
            state_d = IDLE;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

endmodule
